ilog2_pipe: RTL and testbench
=============================

Name: ilog2_pipe

Overview:
- Parametrised, fully pipelined floor(log2) unit for the chaining datapath's gap-cost computation.
- Accepts one unsigned operand per cycle, with a sideband tag, over a valid/ready handshake.
- Returns the position of the leading one, a zero flag and the tag, in issue order.
- Generalises the fixed 32-bit unit: any power-of-two width, binary-search stage per pipeline register, full backpressure, tag passthrough, optional fractional mantissa.

Parameters:
DATA_W, 32, operand width; power of two, 2..64
TAG_W, 8, sideband tag width, passed through unchanged
FRAC_W, 4, fractional bits produced when ILOG2_FRAC_EN is defined; ignored otherwise

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand valid
in_ready  output  1  unit can accept operand this cycle
in_data  input  DATA_W  unsigned operand
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_log2  output  LOG_W  floor(log2(in_data)); LOG_W = $clog2(DATA_W)
out_zero  output  1  operand was 0
out_tag  output  TAG_W  tag of this result
out_frac  output  FRAC_W  fractional mantissa; present only with ILOG2_FRAC_EN

Behaviour:
- Reset is clk-independent. On reset:
  - all stage valids clear; data, exponent, tag and flag regs clear.
  - out_valid=0, out_log2=0, out_zero=0, out_tag=0, out_frac=0; in_ready=1.
- Stage count NS = LOG_W. Stage 0 registers the accepted operand.
- Stage k (1..NS-1) tests the upper half of a remaining window of width DATA_W>>k:
  - if the upper half is nonzero: exponent += DATA_W>>(k+1); keep the upper half.
  - else: keep the lower half.
- Final stage resolves the last bit (window of 2) and registers the outputs.
- Latency: accepted in cycle T -> out_valid in cycle T+NS when no stall occurs (T+NS+1 with ILOG2_FRAC_EN).
- Throughput: 1 result/cycle when out_ready is held high.
- Global advance signal: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - All stages load only when adv=1, else hold.
  - Bubbles (valid=0) propagate as ordinary slots; no bubble collapsing.
- Accept occurs when in_valid && in_ready; transfer occurs when out_valid && out_ready.
- Results are never dropped or duplicated; ordering is strict FIFO.
- out_* are stable while out_valid && !out_ready.
- Zero operand: out_zero=1, out_log2=0, out_frac=0. Any nonzero operand gives out_zero=0.
- Power-of-two operands give the exact exponent. Operand all-ones gives DATA_W-1.
- in_valid=1 while in_ready=0: nothing is accepted; the upstream holds the operand.
- in_valid=0 with adv=1: a bubble enters stage 0.
- Reset mid-stream flushes all in-flight operands; the first accept after reset behaves as from idle.
- Tag is delay-matched through every stage, including the frac stage.

Optional Feature:
- Macro: ILOG2_FRAC_EN.
- Defined:
  - adds one normalisation stage after the exponent stage, and the out_frac port.
  - out_frac = the FRAC_W bits immediately below the leading one (MSB first).
  - missing low bits are zero-padded.
  - gives linear approximation log2(x) ~= out_log2 + out_frac/2^FRAC_W.
  - latency becomes NS+1.
- Undefined: no out_frac port, latency NS, no normalisation shifter.

Test Plan:
- Reset, then single accept in_data=32'h1, tag=8'h5A, out_ready=1 -> out_valid exactly 5 cycles later, out_log2=0, out_zero=0, out_tag=8'h5A.
- Back-to-back 32'h80000000, 32'h00010000, 32'h0000FFFF, 32'h00000100, 32'hFFFFFFFF, tags 1..5 -> out_log2 31,16,15,8,31 on consecutive cycles, tags 1..5, in_ready constantly 1.
- in_data=0 -> out_zero=1, out_log2=0; the next operand 32'h2 -> out_zero=0, out_log2=1.
- Continuous stream 0..9 with out_ready low for 3 cycles mid-stream:
  - in_ready drops the same cycle the output stalls.
  - outputs hold during the stall.
  - all 10 results arrive once, in order, with correct exponents.
- Reset asserted with 3 operands in flight -> out_valid=0 immediately, no stale results after release; new operand 32'h40 -> out_log2=6.
- DATA_W=16, ILOG2_FRAC_EN, FRAC_W=4: 16'h0006 -> log2=2, frac=4'b1000; 16'h0013 -> log2=4, frac=4'b0011; 16'h0001 -> log2=0, frac=0; latency 5 cycles.

Source files
------------

// File: rtl/ilog2_pipe.sv
// ilog2_pipe: fully pipelined floor(log2) with tag passthrough and global valid/ready backpressure.
// Define ILOG2_FRAC_EN to add a normalisation stage and the out_frac mantissa port.
module ilog2_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8,
    parameter int FRAC_W = 4,
    localparam int LOG_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOG_W-1:0]  out_log2,
    output logic              out_zero,
    output logic [TAG_W-1:0]  out_tag
`ifdef ILOG2_FRAC_EN
    ,
    output logic [FRAC_W-1:0] out_frac
`endif
);

    localparam int NS = LOG_W;

    if (DATA_W < 2 || DATA_W > 64 || (DATA_W & (DATA_W - 1)) != 0 || FRAC_W < 1) begin : g_bad_param
        $error("ilog2_pipe: DATA_W must be a power of two in 2..64 and FRAC_W >= 1");
    end

    logic adv;

    // Per-stage slot: window still holding the leading one, exponent found so far.
    logic              vld_q  [NS];
    logic              vld_d  [NS];
    logic              zero_q [NS];
    logic              zero_d [NS];
    logic [LOG_W-1:0]  exp_q  [NS];
    logic [LOG_W-1:0]  exp_d  [NS];
    logic [TAG_W-1:0]  tag_q  [NS];
    logic [TAG_W-1:0]  tag_d  [NS];
    logic [DATA_W-1:0] win_q  [NS];
    logic [DATA_W-1:0] win_d  [NS];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            vld_d[k]  = vld_q[k];
            zero_d[k] = zero_q[k];
            exp_d[k]  = exp_q[k];
            tag_d[k]  = tag_q[k];
            win_d[k]  = win_q[k];
        end
        if (adv) begin
            vld_d[0]  = in_valid;
            zero_d[0] = (in_data == '0);
            tag_d[0]  = in_tag;
            if ((in_data >> (DATA_W / 2)) != '0) begin
                exp_d[0] = LOG_W'(DATA_W / 2);
                win_d[0] = in_data >> (DATA_W / 2);
            end else begin
                exp_d[0] = '0;
                win_d[0] = in_data & ~({DATA_W{1'b1}} << (DATA_W / 2));
            end
            for (int k = 1; k < NS; k++) begin
                vld_d[k]  = vld_q[k-1];
                zero_d[k] = zero_q[k-1];
                tag_d[k]  = tag_q[k-1];
                if ((win_q[k-1] >> (DATA_W >> (k + 1))) != '0) begin
                    exp_d[k] = exp_q[k-1] + LOG_W'(DATA_W >> (k + 1));
                    win_d[k] = win_q[k-1] >> (DATA_W >> (k + 1));
                end else begin
                    exp_d[k] = exp_q[k-1];
                    win_d[k] = win_q[k-1] & ~({DATA_W{1'b1}} << (DATA_W >> (k + 1)));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NS; k++) begin
                vld_q[k]  <= 1'b0;
                zero_q[k] <= 1'b0;
                exp_q[k]  <= '0;
                tag_q[k]  <= '0;
                win_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                vld_q[k]  <= vld_d[k];
                zero_q[k] <= zero_d[k];
                exp_q[k]  <= exp_d[k];
                tag_q[k]  <= tag_d[k];
                win_q[k]  <= win_d[k];
            end
        end
    end

`ifdef ILOG2_FRAC_EN
    // The window discards the bits below the leading one, so the full operand rides alongside.
    logic [DATA_W-1:0] opnd_q [NS];
    logic [DATA_W-1:0] opnd_d [NS];
    logic              fvld_q, fvld_d;
    logic              fzero_q, fzero_d;
    logic [LOG_W-1:0]  flog_q, flog_d;
    logic [TAG_W-1:0]  ftag_q, ftag_d;
    logic [FRAC_W-1:0] frac_q, frac_d;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            opnd_d[k] = opnd_q[k];
        end
        if (adv) begin
            opnd_d[0] = in_data;
            for (int k = 1; k < NS; k++) begin
                opnd_d[k] = opnd_q[k-1];
            end
        end
    end

    // Left-justify the leading one, then take the FRAC_W bits beneath it (zero-padded).
    always_comb begin
        fvld_d  = fvld_q;
        fzero_d = fzero_q;
        flog_d  = flog_q;
        ftag_d  = ftag_q;
        frac_d  = frac_q;
        if (adv) begin
            fvld_d  = vld_q[NS-1];
            fzero_d = zero_q[NS-1];
            flog_d  = exp_q[NS-1];
            ftag_d  = tag_q[NS-1];
            frac_d  = FRAC_W'(({opnd_q[NS-1], {FRAC_W{1'b0}}}
                               << (DATA_W - 1 - int'(exp_q[NS-1]))) >> (DATA_W - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NS; k++) begin
                opnd_q[k] <= '0;
            end
            fvld_q  <= 1'b0;
            fzero_q <= 1'b0;
            flog_q  <= '0;
            ftag_q  <= '0;
            frac_q  <= '0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                opnd_q[k] <= opnd_d[k];
            end
            fvld_q  <= fvld_d;
            fzero_q <= fzero_d;
            flog_q  <= flog_d;
            ftag_q  <= ftag_d;
            frac_q  <= frac_d;
        end
    end

    assign out_valid = fvld_q;
    assign out_zero  = fzero_q;
    assign out_log2  = flog_q;
    assign out_tag   = ftag_q;
    assign out_frac  = frac_q;
`else
    assign out_valid = vld_q[NS-1];
    assign out_zero  = zero_q[NS-1];
    assign out_log2  = exp_q[NS-1];
    assign out_tag   = tag_q[NS-1];
`endif

endmodule

// File: tb/tb_ilog2_pipe.sv
// Directed bench for ilog2_pipe: 32-bit integer build by default, 16-bit fractional build
// when ILOG2_FRAC_EN is defined.
`timescale 1ns/1ps
module tb_ilog2_pipe;

`ifdef ILOG2_FRAC_EN
    localparam int DW  = 16;
`else
    localparam int DW  = 32;
`endif
    localparam int TW  = 8;
    localparam int FW  = 4;
    localparam int LW  = $clog2(DW);
    localparam int LAT = 5;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_log2;
    logic          out_zero;
    logic [TW-1:0] out_tag;
`ifdef ILOG2_FRAC_EN
    logic [FW-1:0] out_frac;
    logic [FW-1:0] exp_frac;
`endif

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    ilog2_pipe #(.DATA_W(DW), .TAG_W(TW), .FRAC_W(FW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_log2  (out_log2),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
`ifdef ILOG2_FRAC_EN
        ,
        .out_frac  (out_frac)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operand: checks latency, result fields and that it appears exactly once.
    task automatic send_one(input logic [63:0] d, input logic [7:0] t, input logic [63:0] el,
                            input logic ez, input string name);
        in_data  = d[DW-1:0];
        in_tag   = t;
        in_valid = 1'b1;
        #1;
        chk({name, "_rdy"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        repeat (LAT - 2) tick();
        chk({name, "_early"}, 64'(out_valid), 64'd0);
        tick();
        chk({name, "_vld"}, 64'(out_valid), 64'd1);
        chk({name, "_log"}, 64'(out_log2), el);
        chk({name, "_zero"}, 64'(out_zero), 64'(ez));
        chk({name, "_tag"}, 64'(out_tag), 64'(t));
`ifdef ILOG2_FRAC_EN
        chk({name, "_frac"}, 64'(out_frac), 64'(exp_frac));
`endif
        tick();
        chk({name, "_once"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        tick();
        tick();
        chk("rst_log", 64'(out_log2), 64'd0);
        chk("rst_zero", 64'(out_zero), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
`ifdef ILOG2_FRAC_EN
        chk("rst_frac", 64'(out_frac), 64'd0);
`endif
        reset = 1'b0;
        tick();

`ifdef ILOG2_FRAC_EN
        exp_frac = 4'b1000;
        send_one(64'h0006, 8'h21, 64'd2, 1'b0, "f6");
        exp_frac = 4'b0011;
        send_one(64'h0013, 8'h22, 64'd4, 1'b0, "f13");
        exp_frac = 4'b0000;
        send_one(64'h0001, 8'h23, 64'd0, 1'b0, "f1");
        exp_frac = 4'b1111;
        send_one(64'hFFFF, 8'h24, 64'd15, 1'b0, "fffff");
        exp_frac = 4'b0000;
        send_one(64'h8000, 8'h25, 64'd15, 1'b0, "f8000");
        exp_frac = 4'b0000;
        send_one(64'h0000, 8'h26, 64'd0, 1'b1, "fzero");
`else
        send_one(64'h1, 8'h5A, 64'd0, 1'b0, "single");

        begin : b2b
            logic [31:0] bd [5];
            int          be [5];
            int          j;
            bd = '{32'h80000000, 32'h00010000, 32'h0000FFFF, 32'h00000100, 32'hFFFFFFFF};
            be = '{31, 16, 15, 8, 31};
            for (int c = 0; c < 5 + LAT; c++) begin
                if (c < 5) begin
                    in_valid = 1'b1;
                    in_data  = bd[c];
                    in_tag   = 8'(c + 1);
                    #1;
                    chk("b2b_rdy", 64'(in_ready), 64'd1);
                end else begin
                    in_valid = 1'b0;
                end
                tick();
                j = c + 1 - LAT;
                if (j >= 0 && j < 5) begin
                    chk("b2b_vld", 64'(out_valid), 64'd1);
                    chk("b2b_log", 64'(out_log2), 64'(be[j]));
                    chk("b2b_tag", 64'(out_tag), 64'(j + 1));
                end
            end
            chk("b2b_end", 64'(out_valid), 64'd0);
        end

        in_valid = 1'b1;
        in_data  = 32'h0;
        in_tag   = 8'hA0;
        tick();
        in_data  = 32'h2;
        in_tag   = 8'hA1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 2) tick();
        chk("z0_vld", 64'(out_valid), 64'd1);
        chk("z0_zero", 64'(out_zero), 64'd1);
        chk("z0_log", 64'(out_log2), 64'd0);
        chk("z0_tag", 64'(out_tag), 64'hA0);
        tick();
        chk("z2_vld", 64'(out_valid), 64'd1);
        chk("z2_zero", 64'(out_zero), 64'd0);
        chk("z2_log", 64'(out_log2), 64'd1);
        chk("z2_tag", 64'(out_tag), 64'hA1);
        tick();

        begin : stream
            int  sl [10];
            int  tx;
            int  rx;
            int  extra;
            logic stall;
            sl    = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3};
            tx    = 0;
            rx    = 0;
            extra = 0;
            for (int c = 0; c < 40; c++) begin
                stall     = (c >= 7 && c <= 9);
                out_ready = !stall;
                in_valid  = (tx < 10);
                in_data   = DW'(tx);
                in_tag    = 8'(8'h10 + tx);
                #1;
                if (stall) begin
                    chk("st_vld", 64'(out_valid), 64'd1);
                    chk("st_rdy", 64'(in_ready), 64'd0);
                end else begin
                    chk("sm_rdy", 64'(in_ready), 64'd1);
                end
                if (out_valid) begin
                    if (rx < 10) begin
                        chk("sm_log", 64'(out_log2), 64'(sl[rx]));
                        chk("sm_zero", 64'(out_zero), 64'(rx == 0));
                        chk("sm_tag", 64'(out_tag), 64'(8'h10 + rx));
                    end else begin
                        extra++;
                    end
                    if (out_ready) rx++;
                end
                if (in_valid && in_ready) tx++;
                tick();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("sm_tx", 64'(tx), 64'd10);
            chk("sm_rx", 64'(rx), 64'd10);
            chk("sm_extra", 64'(extra), 64'd0);
        end

        begin : midrst
            int stale;
            for (int c = 0; c < 3; c++) begin
                in_valid = 1'b1;
                in_data  = DW'(7 + c);
                in_tag   = 8'(8'h30 + c);
                tick();
            end
            in_valid = 1'b0;
            repeat (LAT - 3) tick();
            chk("mr_pre", 64'(out_valid), 64'd1);
            #2;
            reset = 1'b1;
            #1;
            chk("mr_vld", 64'(out_valid), 64'd0);
            chk("mr_rdy", 64'(in_ready), 64'd1);
            chk("mr_tag", 64'(out_tag), 64'd0);
            tick();
            tick();
            reset = 1'b0;
            stale = 0;
            repeat (12) begin
                tick();
                if (out_valid) stale++;
            end
            chk("mr_stale", 64'(stale), 64'd0);
            send_one(64'h40, 8'h77, 64'd6, 1'b0, "post_rst");
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
